// File: rtl/stream_mux_rr.sv
// N_CH-to-1 valid/ready stream mux with fixed-select or round-robin arbitration; `STREAM_MUX_LOCK_EN adds in_last/out_last packet lock.
// Registered output, 1-cycle latency at 1 word/cycle; in_ready follows out_ready combinationally and is all low while the output stalls.
module stream_mux_rr #(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 2,
   localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mode,
   input  logic [SEL_W-1:0]       sel,
   input  logic [N_CH*DATA_W-1:0] in_data,
   input  logic [N_CH-1:0]        in_valid,
   output logic [N_CH-1:0]        in_ready,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [N_CH-1:0]        in_last,
   output logic                   out_last,
`endif
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SEL_W-1:0]       out_ch
);

   logic              r_out_vld;
   logic [DATA_W-1:0] r_out_dat;
   logic [SEL_W-1:0]  r_out_ch;
   logic [SEL_W-1:0]  r_rr_ptr;

   logic              w_load_en;
   logic              w_grant_vld;
   logic [SEL_W-1:0]  w_grant_idx;
   logic [DATA_W-1:0] w_grant_dat;
   logic [SEL_W-1:0]  w_rr_next;
   logic              w_hi_vld;
   logic [SEL_W-1:0]  w_hi_idx;
   logic              w_lo_vld;
   logic [SEL_W-1:0]  w_lo_idx;

`ifdef STREAM_MUX_LOCK_EN
   logic              r_locked;
   logic [SEL_W-1:0]  r_lock_ch;
   logic              r_out_last;
   logic              w_grant_last;
`endif

   assign w_load_en = !r_out_vld || out_ready;

   // Round-robin: lowest valid at or above rr_ptr, else wrap to lowest valid overall.
   always_comb begin
      w_hi_vld = 1'b0;
      w_hi_idx = '0;
      w_lo_vld = 1'b0;
      w_lo_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            w_lo_vld = 1'b1;
            w_lo_idx = SEL_W'(i);
            if (SEL_W'(i) >= r_rr_ptr) begin
               w_hi_vld = 1'b1;
               w_hi_idx = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
`ifdef STREAM_MUX_LOCK_EN
      if (r_locked) begin
         for (int i = 0; i < N_CH; i++) begin
            if (r_lock_ch == SEL_W'(i) && in_valid[i]) begin
               w_grant_vld = 1'b1;
               w_grant_idx = SEL_W'(i);
            end
         end
      end else
`endif
      if (!mode) begin
         for (int i = 0; i < N_CH; i++) begin
            if ((N_CH == 1 || sel == SEL_W'(i)) && in_valid[i]) begin
               w_grant_vld = 1'b1;
               w_grant_idx = SEL_W'(i);
            end
         end
      end else begin
         w_grant_vld = w_lo_vld;
         w_grant_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
      end
   end

   always_comb begin
      w_grant_dat = '0;
      in_ready    = '0;
`ifdef STREAM_MUX_LOCK_EN
      w_grant_last = 1'b0;
`endif
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant_idx == SEL_W'(i)) begin
            w_grant_dat = in_data[i*DATA_W +: DATA_W];
            in_ready[i] = w_load_en && w_grant_vld;
`ifdef STREAM_MUX_LOCK_EN
            w_grant_last = in_last[i];
`endif
         end
      end
   end

   assign w_rr_next = (w_grant_idx == SEL_W'(N_CH - 1)) ? '0 : w_grant_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
         r_out_ch  <= '0;
         r_rr_ptr  <= '0;
`ifdef STREAM_MUX_LOCK_EN
         r_locked   <= 1'b0;
         r_lock_ch  <= '0;
         r_out_last <= 1'b0;
`endif
      end else if (w_load_en) begin
         r_out_vld <= w_grant_vld;
         if (w_grant_vld) begin
            r_out_dat <= w_grant_dat;
            r_out_ch  <= w_grant_idx;
            r_rr_ptr  <= w_rr_next;
`ifdef STREAM_MUX_LOCK_EN
            r_locked   <= !w_grant_last;
            r_lock_ch  <= w_grant_idx;
            r_out_last <= w_grant_last;
`endif
         end
      end
   end

   assign out_valid = r_out_vld;
   assign out_data  = r_out_dat;
   assign out_ch    = r_out_ch;
`ifdef STREAM_MUX_LOCK_EN
   assign out_last  = r_out_last;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenario tasks plus a cycle scoreboard of granted words.
`timescale 1ns/1ps
module tb_stream_mux_rr;

   localparam int N_CH   = 4;
   localparam int DATA_W = 2;
   localparam int SEL_W  = 2;

   logic                   clk       = 1'b0;
   logic                   rst_n     = 1'b0;
   logic                   mode      = 1'b0;
   logic [SEL_W-1:0]       sel       = '0;
   logic [N_CH*DATA_W-1:0] in_data   = '0;
   logic [N_CH-1:0]        in_valid  = '0;
   logic [N_CH-1:0]        in_ready;
   logic [DATA_W-1:0]      out_data;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   logic [SEL_W-1:0]       out_ch;
   logic                   act_last;
`ifdef STREAM_MUX_LOCK_EN
   logic [N_CH-1:0]        in_last   = '0;
   logic                   out_last;
   assign act_last = out_last;
`else
   assign act_last = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0]       word_of [N_CH];
   logic [N_CH*DATA_W-1:0]  words;

   logic [SEL_W+DATA_W:0]   sb_q [$];
   logic                    mdl_vld, mdl_lock, m_gv, m_load, m_last;
   logic [SEL_W-1:0]        mdl_rr, mdl_lock_ch, m_g, m_c;
   logic [N_CH-1:0]         exp_rdy;

   stream_mux_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .sel      (sel),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
`ifdef STREAM_MUX_LOCK_EN
      .in_last  (in_last),
      .out_last (out_last),
`endif
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ch   (out_ch)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   // Reference model: sampled mid-cycle, predicts in_ready and pushes the word each transfer will register.
   always @(negedge clk) begin
      if (!rst_n) begin
         mdl_vld = 1'b0; mdl_rr = '0; mdl_lock = 1'b0; mdl_lock_ch = '0;
         sb_q.delete();
      end else begin
         n_tests++;
         if (out_valid !== mdl_vld) begin
            n_fail++;
            $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, mdl_vld, $time);
         end
         if (mdl_vld) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_underflow: got empty queue expected one entry at %0t", $time);
            end else begin
               if ({act_last, out_ch, out_data} !== sb_q[0]) begin
                  n_fail++;
                  $display("FAIL sb_word: got last/ch/data %b expected %b at %0t",
                           {act_last, out_ch, out_data}, sb_q[0], $time);
               end
               if (out_ready) void'(sb_q.pop_front());
            end
         end
         m_gv = 1'b0; m_g = '0;
         if (mdl_lock) begin
            if (in_valid[mdl_lock_ch]) begin m_gv = 1'b1; m_g = mdl_lock_ch; end
         end else if (!mode) begin
            if (int'(sel) < N_CH && in_valid[sel]) begin m_gv = 1'b1; m_g = sel; end
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               m_c = SEL_W'((int'(mdl_rr) + k) % N_CH);
               if (!m_gv && in_valid[m_c]) begin m_gv = 1'b1; m_g = m_c; end
            end
         end
         m_load  = !mdl_vld || out_ready;
         exp_rdy = '0;
         if (m_load && m_gv) exp_rdy[m_g] = 1'b1;
         n_tests++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
         end
         if (m_load) begin
            mdl_vld = m_gv;
            if (m_gv) begin
               m_last = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
               m_last      = in_last[m_g];
               mdl_lock    = !m_last;
               mdl_lock_ch = m_g;
`endif
               sb_q.push_back({m_last, m_g, in_data[m_g*DATA_W +: DATA_W]});
               mdl_rr = SEL_W'((int'(m_g) + 1) % N_CH);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1; in_data = words;
`ifdef STREAM_MUX_LOCK_EN
      in_last = '0;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      mode = 1'b1; in_valid = '1;
      repeat (3) tick();
      n_tests++;
      if (out_ch !== 2'd2 || out_data !== 2'b11 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre: got v=%b ch=%0d d=%b expected v=1 ch=2 d=11", out_valid, out_ch, out_data);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_tests++;
      if (out_data !== 2'b00) begin n_fail++; $display("FAIL reset_data: got %b expected 00", out_data); end
      n_tests++;
      if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_rdy: got %b expected 0001", in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_first_grant: got v=%b ch=%0d d=%b expected v=1 ch=0 d=10", out_valid, out_ch, out_data);
      end
   endtask

   task automatic test_fixed_sel();
      logic [N_CH-1:0] er;
      do_reset();
      in_valid = '1;
      for (int s = 0; s < N_CH; s++) begin
         sel = SEL_W'(s);
         er  = 4'b0001 << s;
         @(negedge clk);
         n_tests++;
         if (in_ready !== er) begin n_fail++; $display("FAIL fixed_rdy sel=%0d: got %b expected %b", s, in_ready, er); end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_ch !== SEL_W'(s) || out_data !== word_of[s]) begin
            n_fail++;
            $display("FAIL fixed_out sel=%0d: got v=%b ch=%0d d=%b expected v=1 ch=%0d d=%b",
                     s, out_valid, out_ch, out_data, s, word_of[s]);
         end
         repeat (9) tick();
      end
   endtask

   task automatic test_round_robin();
      logic [N_CH-1:0] er;
      do_reset();
      mode = 1'b1; in_valid = '1;
      for (int k = 0; k < 6; k++) begin
         er = 4'b0001 << (k % N_CH);
         @(negedge clk);
         n_tests++;
         if (in_ready !== er) begin n_fail++; $display("FAIL rr_rdy step %0d: got %b expected %b", k, in_ready, er); end
         tick();
         n_tests++;
         if (out_ch !== SEL_W'(k % N_CH) || out_data !== word_of[k % N_CH]) begin
            n_fail++;
            $display("FAIL rr_out step %0d: got ch=%0d d=%b expected ch=%0d d=%b",
                     k, out_ch, out_data, k % N_CH, word_of[k % N_CH]);
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      mode = 1'b1; in_valid = '1;
      repeat (2) tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (in_ready !== 4'b0000 || out_ch !== 2'd1 || out_data !== 2'b00 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold %0d: got rdy=%b v=%b ch=%0d d=%b expected rdy=0000 v=1 ch=1 d=00",
                     k, in_ready, out_valid, out_ch, out_data);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_resume_rdy: got %b expected 0100", in_ready); end
      tick();
      n_tests++;
      if (out_ch !== 2'd2) begin n_fail++; $display("FAIL stall_resume_ch: got %0d expected 2", out_ch); end
   endtask

   task automatic test_sparse();
      logic [N_CH-1:0]  vld_tab [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1011};
      logic [SEL_W-1:0] ch_tab  [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1};
      do_reset();
      mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = vld_tab[k];
         tick();
         n_tests++;
         if (out_ch !== ch_tab[k] || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse step %0d: got v=%b ch=%0d expected v=1 ch=%0d", k, out_valid, out_ch, ch_tab[k]);
         end
      end
   endtask

   task automatic test_sel_invalid();
      do_reset();
      in_valid = '1; sel = 2'd0;
      tick();
      sel = 2'd2; in_valid = 4'b1011;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL selinv_rdy: got rdy=%b v=%b expected rdy=0000 v=1", in_ready, out_valid);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 2'b10 || out_ch !== 2'd0) begin
         n_fail++;
         $display("FAIL selinv_drain: got v=%b d=%b ch=%0d expected v=0 d=10 ch=0", out_valid, out_data, out_ch);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         mode      = 1'($urandom_range(0, 1));
         sel       = SEL_W'($urandom_range(0, N_CH - 1));
         in_data   = (N_CH*DATA_W)'($urandom);
         in_valid  = N_CH'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
         in_last   = N_CH'($urandom);
`endif
         tick();
      end
      in_valid = '0; out_ready = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d queued expected 0", sb_q.size()); end
   endtask

`ifdef STREAM_MUX_LOCK_EN
   task automatic test_lock();
      logic [SEL_W-1:0] ch_tab   [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
      logic             last_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      in_valid = 4'b0111; sel = 2'd1;
      for (int k = 0; k < 4; k++) begin
         mode    = (k != 0);
         in_last = (k == 2) ? 4'b0010 : 4'b0000;
         tick();
         n_tests++;
         if (out_ch !== ch_tab[k] || out_last !== last_tab[k]) begin
            n_fail++;
            $display("FAIL lock beat %0d: got ch=%0d last=%b expected ch=%0d last=%b",
                     k, out_ch, out_last, ch_tab[k], last_tab[k]);
         end
      end
   endtask
`endif

   initial begin
      word_of[0] = 2'b10; word_of[1] = 2'b00; word_of[2] = 2'b11; word_of[3] = 2'b01;
      words = {word_of[3], word_of[2], word_of[1], word_of[0]};
      test_reset();
      test_fixed_sel();
      test_round_robin();
      test_stall();
      test_sparse();
      test_sel_invalid();
`ifdef STREAM_MUX_LOCK_EN
      test_lock();
`endif
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel stream multiplexer; successor to the small combinational 4:1 select muxes.
- Adds per-channel valid/ready handshake, a registered output stage, and a choice of fixed-select or round-robin arbitration.
- Merges several producer streams onto one consumer link, e.g. feeding a shared datapath or a debug/trace port.

Parameters:
- N_CH, 4, number of input channels (>=1).
- DATA_W, 2, width of each channel's data word (>=1).
- SEL_W, derived localparam = max(1, clog2(N_CH)), not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = fixed select by sel; 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- in_data  in  N_CH*DATA_W  channel i occupies [i*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; at most one bit high.
- out_data  out  DATA_W  registered output word.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_ch  out  SEL_W  source channel of the current out_data.

Behaviour:
- Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Any held word is discarded; no partial state survives.
- load_en = !out_valid || out_ready. This is combinational, so in_ready depends combinationally on out_ready (no skid buffer).
- Grant candidate g:
  - mode=0: g=sel if sel<N_CH and in_valid[sel]; otherwise no grant.
  - mode=1: first channel with in_valid set, scanning from rr_ptr upward and wrapping at N_CH-1 to 0.
- in_ready[g] = load_en && grant exists. All other in_ready bits are 0.
- Transfer on in_valid[g] && in_ready[g]. At the next edge: out_data <= word g, out_ch <= g, out_valid <= 1. Latency is 1 cycle and throughput is 1 word/cycle.
- load_en=1 with no grant: out_valid <= 0 at the next edge; out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch, out_valid and rr_ptr are all frozen; in_ready is all 0.
- rr_ptr update: on each transfer, rr_ptr <= (g==N_CH-1) ? 0 : g+1, in both modes. A switch to mode=1 therefore continues after the last served channel.
- Changes to mode or sel take effect on the next grant decision only. A word already held in the output register is never altered or dropped.
- sel >= N_CH (non-power-of-two N_CH): no grant, in_ready all 0.
- N_CH=1: the single channel is always the candidate; out_ch is constant 0.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN
- Enabled:
  - Adds input in_last[N_CH] and output out_last, registered alongside out_data with reset value 0.
  - After a transfer with in_last[g]=0, the grant is locked to g and ignores mode, sel and rr_ptr.
  - The lock releases on the transfer carrying in_last[g]=1; rr_ptr then advances past g.
  - rst_n clears the lock.
- Disabled: in_last and out_last ports are absent, and every beat is arbitrated independently.

Test Plan:
- Async reset mid-stream (rst_n low between edges while out_valid=1) -> out_valid=0, out_data=0, out_ch=0 immediately; first grant after release in mode=1 is ch0.
- N_CH=4, DATA_W=2, words ch0..3 = 10,00,11,01, all valid, out_ready=1, mode=0, sel stepping 0,1,2,3 every 10 cycles -> out_data 10,00,11,01 with out_ch=sel, each one edge after sel changes.
- mode=1, all four valid continuously, out_ready=1 -> out_ch 0,1,2,3,0,1 on successive cycles; in_ready one-hot rotating 0001,0010,0100,1000.
- mode=1, out_ready=0 for 3 cycles while out_valid=1 (out_ch=1) -> out_data/out_ch held and in_ready=0000; when out_ready rises, next grant is ch2.
- mode=1, only ch1 and ch3 valid -> out_ch 1,3,1,3; raise in_valid[0] in the cycle ch3 transfers -> next out_ch=0, then 1.
- mode=0, sel=2, in_valid[2]=0, others valid -> in_ready=0000 and out_valid falls after the held word drains. With STREAM_MUX_LOCK_EN: a 3-beat packet on ch1 (in_last on beat 3) while ch0 and ch2 are valid -> out_ch 1,1,1,2.
